bp_stall_hist_reader: RTL and testbench

BP_STALL_HIST_READER -- requirements
Module: bp_stall_hist_reader

---
 rtl/bp_stall_hist_reader_if.sv | 24 ++
 rtl/bp_stall_hist_reader.sv | 182 ++++++++++++++++++
 tb/tb_bp_stall_hist_reader.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bp_stall_hist_reader_if.sv
// Host read channel of the stall-histogram reader: request, response and consume handshake.
// Signal suffixes are named from the block's side of the link.
interface bp_stall_hist_reader_if #(
    parameter int addr_width_p    = 8,
    parameter int counter_width_p = 32
);
    logic                       rd_v_i;
    logic [addr_width_p-1:0]    rd_addr_i;
    logic                       rd_ready_o;
    logic                       rd_v_o;
    logic [counter_width_p-1:0] rd_data_o;
    logic                       rd_err_o;
    logic                       rd_yumi_i;

    modport master (
        output rd_v_i, rd_addr_i, rd_yumi_i,
        input  rd_ready_o, rd_v_o, rd_data_o, rd_err_o
    );

    modport slave (
        input  rd_v_i, rd_addr_i, rd_yumi_i,
        output rd_ready_o, rd_v_o, rd_data_o, rd_err_o
    );
endinterface

// File: rtl/bp_stall_hist_reader.sv
// Stall-reason histogram: saturating per-reason, retired-instruction and cycle counters,
// readable over a one-outstanding host channel and zeroed by a one-counter-per-cycle sweep.
module bp_stall_hist_reader #(
    parameter int num_reasons_p   = 64,
    parameter int reason_width_p  = 6,
    parameter int counter_width_p = 32,
    parameter int addr_width_p    = 8
) (
    input  logic                      clk_i,
    input  logic                      reset_li,
    input  logic                      en_i,
    input  logic                      instret_i,
    input  logic                      stall_v_i,
    input  logic [reason_width_p-1:0] stall_reason_i,
    input  logic                      clear_i,
    bp_stall_hist_reader_if.slave     rd_if,
    output logic                      clearing_o
);
    // Counters share one array: reasons first, then instr_cnt, then cycle_cnt.
    localparam int num_cnt_lp   = num_reasons_p + 2;
    localparam int idx_width_lp = $clog2(num_cnt_lp);
    localparam int instr_idx_lp = num_reasons_p;
    localparam int cycle_idx_lp = num_reasons_p + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, RESP = 2'd1, CLEAR = 2'd2} state_e;

    function automatic logic [counter_width_p-1:0] sat_inc(input logic [counter_width_p-1:0] v);
        return (&v) ? v : v + counter_width_p'(1);
    endfunction

    state_e                     state_q, state_d;
    logic                       pend_q, pend_d;
    logic [idx_width_lp-1:0]    sweep_idx_q, sweep_idx_d;
    logic                       smp_en_q, smp_en_d;
    logic                       smp_instret_q, smp_instret_d;
    logic                       smp_stall_v_q, smp_stall_v_d;
    logic [reason_width_p-1:0]  smp_reason_q, smp_reason_d;
    logic [counter_width_p-1:0] cnt_q [num_cnt_lp];
    logic [counter_width_p-1:0] cnt_d [num_cnt_lp];
    logic                       rd_v_q, rd_v_d;
    logic [counter_width_p-1:0] rd_data_q, rd_data_d;
    logic                       rd_err_q, rd_err_d;
    logic                       ready_q, ready_d;
    logic                       clearing_q, clearing_d;
    logic [num_cnt_lp-1:0]      inc_s;
    logic                       stall_inc_s;
    logic                       addr_hit_s;

    // Sample stage inputs.
    always_comb begin
        smp_en_d      = en_i;
        smp_instret_d = instret_i;
        smp_stall_v_d = stall_v_i;
        smp_reason_d  = stall_reason_i;
    end

    // Which counters step this cycle; a retire suppresses the stall count.
    always_comb begin
        stall_inc_s = smp_en_q & ~smp_instret_q & smp_stall_v_q;
        inc_s       = '0;
        for (int i = 0; i < num_reasons_p; i++) begin
            inc_s[i] = stall_inc_s && (smp_reason_q == reason_width_p'(i));
        end
        inc_s[instr_idx_lp] = smp_en_q & smp_instret_q;
        inc_s[cycle_idx_lp] = smp_en_q;
    end

    // Counter next values; the sweep owns all counters while clearing.
    always_comb begin
        for (int i = 0; i < num_cnt_lp; i++) begin
            if (state_q == CLEAR) begin
                cnt_d[i] = (sweep_idx_q == idx_width_lp'(i)) ? '0 : cnt_q[i];
            end else if (inc_s[i]) begin
                cnt_d[i] = sat_inc(cnt_q[i]);
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    assign addr_hit_s = rd_if.rd_addr_i < addr_width_p'(num_cnt_lp);

    // Read/clear FSM next state, pending-clear flag and response registers.
    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        sweep_idx_d = sweep_idx_q;
        rd_v_d      = rd_v_q;
        rd_data_d   = rd_data_q;
        rd_err_d    = rd_err_q;
        case (state_q)
            IDLE: begin
                if (pend_q) begin
                    state_d     = CLEAR;
                    pend_d      = 1'b0;
                    sweep_idx_d = '0;
                end else if (rd_if.rd_v_i) begin
                    state_d = RESP;
                    pend_d  = clear_i;
                    rd_v_d  = 1'b1;
                    if (addr_hit_s) begin
                        rd_data_d = cnt_q[rd_if.rd_addr_i[idx_width_lp-1:0]];
                        rd_err_d  = 1'b0;
                    end else begin
                        rd_data_d = '0;
                        rd_err_d  = 1'b1;
                    end
                end else begin
                    pend_d = clear_i;
                end
            end
            RESP: begin
                pend_d = pend_q | clear_i;
                if (rd_if.rd_yumi_i) begin
                    state_d   = IDLE;
                    rd_v_d    = 1'b0;
                    rd_data_d = '0;
                    rd_err_d  = 1'b0;
                end else begin
                    state_d = RESP;
                end
            end
            CLEAR: begin
                if (sweep_idx_q == idx_width_lp'(num_cnt_lp - 1)) begin
                    state_d     = IDLE;
                    sweep_idx_d = '0;
                end else begin
                    sweep_idx_d = sweep_idx_q + idx_width_lp'(1);
                end
            end
            default: begin
                state_d = IDLE;
                pend_d  = 1'b0;
                rd_v_d  = 1'b0;
            end
        endcase
        ready_d    = (state_d == IDLE) && !pend_d;
        clearing_d = (state_d == CLEAR);
    end

    // State, sample stage, counters and registered outputs.
    always_ff @(posedge clk_i or negedge reset_li) begin
        if (!reset_li) begin
            state_q       <= IDLE;
            pend_q        <= 1'b0;
            sweep_idx_q   <= '0;
            smp_en_q      <= 1'b0;
            smp_instret_q <= 1'b0;
            smp_stall_v_q <= 1'b0;
            smp_reason_q  <= '0;
            for (int i = 0; i < num_cnt_lp; i++) begin
                cnt_q[i] <= '0;
            end
            rd_v_q        <= 1'b0;
            rd_data_q     <= '0;
            rd_err_q      <= 1'b0;
            ready_q       <= 1'b1;
            clearing_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pend_q        <= pend_d;
            sweep_idx_q   <= sweep_idx_d;
            smp_en_q      <= smp_en_d;
            smp_instret_q <= smp_instret_d;
            smp_stall_v_q <= smp_stall_v_d;
            smp_reason_q  <= smp_reason_d;
            cnt_q         <= cnt_d;
            rd_v_q        <= rd_v_d;
            rd_data_q     <= rd_data_d;
            rd_err_q      <= rd_err_d;
            ready_q       <= ready_d;
            clearing_q    <= clearing_d;
        end
    end

    // Idle resets with ready set so the first post-reset cycle accepts; mask it while in reset.
    assign rd_if.rd_ready_o = ready_q & reset_li;
    assign rd_if.rd_v_o     = rd_v_q;
    assign rd_if.rd_data_o  = rd_data_q;
    assign rd_if.rd_err_o   = rd_err_q;
    assign clearing_o       = clearing_q;
endmodule

// File: tb/tb_bp_stall_hist_reader.sv
// Randomized and directed checks of the stall histogram reader against a per-edge counting model.
module tb_bp_stall_hist_reader;
    localparam int nr_lp      = 64;
    localparam int rw_lp      = 6;
    localparam int cw_lp      = 4;
    localparam int aw_lp      = 8;
    localparam int max_lp     = (1 << cw_lp) - 1;
    localparam int nc_lp      = nr_lp + 2;

    logic             clk_i = 1'b0;
    logic             reset_li = 1'b0;
    logic             en_i = 1'b0;
    logic             instret_i = 1'b0;
    logic             stall_v_i = 1'b0;
    logic [rw_lp-1:0] stall_reason_i = '0;
    logic             clear_i = 1'b0;
    logic             clearing_o;

    bp_stall_hist_reader_if #(.addr_width_p(aw_lp), .counter_width_p(cw_lp)) rd_if ();

    bp_stall_hist_reader #(
        .num_reasons_p(nr_lp), .reason_width_p(rw_lp),
        .counter_width_p(cw_lp), .addr_width_p(aw_lp)
    ) dut (
        .clk_i(clk_i), .reset_li(reset_li), .en_i(en_i), .instret_i(instret_i),
        .stall_v_i(stall_v_i), .stall_reason_i(stall_reason_i), .clear_i(clear_i),
        .rd_if(rd_if), .clearing_o(clearing_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference: counter values plus last-sampled inputs and a clear window.
    int   model_cnt [nc_lp];
    logic m_en, m_ret, m_stall;
    int   m_reason;
    int   clr_left, clr_arm;
    int   reason_tbl [5] = '{0, 1, 2, 3, 63};

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < nc_lp; i++) model_cnt[i] = 0;
        m_en = 1'b0; m_ret = 1'b0; m_stall = 1'b0; m_reason = 0;
        clr_left = 0; clr_arm = 0;
    endtask

    task automatic bump(input int i);
        model_cnt[i] = (model_cnt[i] >= max_lp) ? max_lp : model_cnt[i] + 1;
    endtask

    // Apply one clock edge to the model: last cycle's sample counts unless a clear is running.
    task automatic model_edge();
        if (clr_left > 0) begin
            for (int i = 0; i < nc_lp; i++) model_cnt[i] = 0;
            clr_left--;
        end else if (m_en) begin
            bump(nc_lp - 1);
            if (m_ret) bump(nr_lp);
            else if (m_stall) bump(m_reason);
        end
        if (clr_arm != 0) begin
            clr_arm  = 0;
            clr_left = nc_lp;
        end else if (clear_i && clr_left == 0) begin
            clr_arm = 1;
        end
        m_en = en_i; m_ret = instret_i; m_stall = stall_v_i; m_reason = int'(stall_reason_i);
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_edge();
        @(negedge clk_i);
    endtask

    task automatic set_stim(input logic en, input logic ret, input logic sv, input int reason);
        en_i = en; instret_i = ret; stall_v_i = sv; stall_reason_i = reason[rw_lp-1:0];
    endtask

    task automatic do_reset();
        reset_li = 1'b0;
        model_reset();
        @(negedge clk_i);
        reset_li = 1'b1;
    endtask

    task automatic do_read(input int addr, input int hold, input string tag);
        int   budget;
        int   exp_d;
        logic exp_e;
        budget = 0;
        while (!rd_if.rd_ready_o && budget < 200) begin
            tick();
            budget++;
        end
        check_eq({tag, " ready"}, rd_if.rd_ready_o, 1);
        rd_if.rd_v_i    = 1'b1;
        rd_if.rd_addr_i = addr[aw_lp-1:0];
        exp_d = (addr < nc_lp) ? model_cnt[addr] : 0;
        exp_e = (addr < nc_lp) ? 1'b0 : 1'b1;
        check_eq({tag, " v_before"}, rd_if.rd_v_o, 0);
        tick();
        rd_if.rd_v_i = 1'b0;
        check_eq({tag, " v"}, rd_if.rd_v_o, 1);
        check_eq({tag, " data"}, rd_if.rd_data_o, exp_d);
        check_eq({tag, " err"}, rd_if.rd_err_o, exp_e);
        for (int k = 0; k < hold; k++) begin
            tick();
            check_eq({tag, " hold_v"}, rd_if.rd_v_o, 1);
            check_eq({tag, " hold_data"}, rd_if.rd_data_o, exp_d);
            check_eq({tag, " hold_err"}, rd_if.rd_err_o, exp_e);
            check_eq({tag, " hold_ready"}, rd_if.rd_ready_o, 0);
        end
        rd_if.rd_yumi_i = 1'b1;
        tick();
        rd_if.rd_yumi_i = 1'b0;
        check_eq({tag, " v_after"}, rd_if.rd_v_o, 0);
    endtask

    // Pulse clear and wait until the sweep is visible; returns false on timeout.
    task automatic start_clear(output bit seen);
        int budget;
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        budget = 0;
        while (!clearing_o && budget < 10) begin
            tick();
            budget++;
        end
        seen = clearing_o;
        check_eq("clear_start", clearing_o, 1);
    endtask

    initial begin
        bit seen;
        int len;
        int sel;
        int addr;
        rd_if.rd_v_i = 1'b0; rd_if.rd_addr_i = '0; rd_if.rd_yumi_i = 1'b0;
        model_reset();
        repeat (3) @(negedge clk_i);
        check_eq("rst_v", rd_if.rd_v_o, 0);
        check_eq("rst_data", rd_if.rd_data_o, 0);
        check_eq("rst_err", rd_if.rd_err_o, 0);
        check_eq("rst_clearing", clearing_o, 0);
        check_eq("rst_ready", rd_if.rd_ready_o, 0);
        reset_li = 1'b1;
        #1;
        check_eq("post_rst_ready", rd_if.rd_ready_o, 1);

        // Ten stall cycles on reason 5, then idle.
        set_stim(1'b1, 1'b0, 1'b1, 5);
        repeat (10) tick();
        set_stim(1'b0, 1'b0, 1'b0, 0);
        repeat (2) tick();
        do_read(5, 0, "cnt_r5");
        do_read(65, 0, "cnt_cycle");

        // Retire wins over a valid stall.
        set_stim(1'b1, 1'b1, 1'b1, 3);
        repeat (4) tick();
        set_stim(1'b0, 1'b0, 1'b0, 0);
        repeat (2) tick();
        do_read(64, 0, "instr");
        do_read(3, 0, "retire_prio_r3");

        // Out-of-range address with backpressure.
        do_read(200, 5, "bad_addr");

        // Saturation.
        set_stim(1'b1, 1'b0, 1'b1, 0);
        repeat (20) tick();
        set_stim(1'b0, 1'b0, 1'b0, 0);
        repeat (2) tick();
        do_read(0, 0, "sat_r0");
        do_read(65, 0, "sat_cycle");

        // Read accepted while the same counter increments returns the old value.
        set_stim(1'b1, 1'b0, 1'b1, 7);
        repeat (3) tick();
        do_read(7, 0, "pre_inc_r7");
        set_stim(1'b0, 1'b0, 1'b0, 0);
        repeat (2) tick();
        do_read(7, 0, "post_inc_r7");

        // Random traffic from fresh reset.
        for (int it = 0; it < 6; it++) begin
            do_reset();
            for (int c = 0; c < 12; c++) begin
                set_stim(($urandom % 4) != 0, ($urandom % 3) == 0, ($urandom % 2) == 0,
                         reason_tbl[$urandom_range(0, 4)]);
                tick();
            end
            for (int r = 0; r < 4; r++) begin
                sel = $urandom_range(0, 7);
                if (sel < 5) addr = reason_tbl[sel];
                else if (sel == 7) addr = $urandom_range(nc_lp, 255);
                else addr = nr_lp + sel - 5;
                do_read(addr, r % 2, "rand");
            end
            set_stim(1'b0, 1'b0, 1'b0, 0);
        end

        // Clear sweep while stalling continuously; a second pulse mid-sweep is ignored.
        do_reset();
        set_stim(1'b1, 1'b0, 1'b1, 5);
        repeat (3) tick();
        start_clear(seen);
        len = 0;
        while (clearing_o && len < 200) begin
            if (len == 20) begin
                check_eq("clear_ready_low", rd_if.rd_ready_o, 0);
                clear_i = 1'b1;
            end
            tick();
            clear_i = 1'b0;
            len++;
        end
        check_eq("clear_len", len, nc_lp);
        check_eq("clear_done_ready", rd_if.rd_ready_o, 1);
        repeat (4) tick();
        set_stim(1'b0, 1'b0, 1'b0, 0);
        repeat (2) tick();
        do_read(5, 0, "after_clear_r5");
        do_read(65, 0, "after_clear_cycle");

        // Reset in the middle of a sweep.
        set_stim(1'b1, 1'b0, 1'b1, 9);
        repeat (3) tick();
        start_clear(seen);
        repeat (10) tick();
        #2;
        reset_li = 1'b0;
        model_reset();
        set_stim(1'b0, 1'b0, 1'b0, 0);
        #1;
        check_eq("midclr_rst_v", rd_if.rd_v_o, 0);
        check_eq("midclr_rst_clearing", clearing_o, 0);
        check_eq("midclr_rst_ready", rd_if.rd_ready_o, 0);
        @(negedge clk_i);
        reset_li = 1'b1;
        #1;
        check_eq("midclr_ready", rd_if.rd_ready_o, 1);
        check_eq("midclr_clearing", clearing_o, 0);
        do_read(0, 0, "midclr_r0");
        do_read(9, 0, "midclr_r9");
        do_read(64, 0, "midclr_instr");
        do_read(65, 0, "midclr_cycle");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
